param_stack: RTL and testbench

//  Parametrised LIFO stack with full/empty/count status, overflow/underflow error pulses,
//  a same-cycle push+pop (swap) mode and a combinational top-of-stack peek.

---
 rtl/param_stack_pkg.sv | 27 ++
 rtl/param_stack_ram.sv | 27 ++
 rtl/param_stack.sv | 147 ++++++++++++++
 tb/tb_param_stack.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/param_stack_pkg.sv
// Shared constants, operation encoding and sizing helper for the stack and
// future queue/FIFO blocks.
package param_stack_pkg;

    localparam int DEFAULT_WIDTH = 3;
    localparam int DEFAULT_DEPTH = 512;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } stack_op_e;

    // Smallest r with 2**r >= value; constant-evaluable for parameter sizing.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (int'(32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/param_stack_ram.sv
// Stack storage: one synchronous write port and one asynchronous read port.
// The single read port serves both the top-of-stack peek and pop/swap capture.
module stack_ram #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port; contents are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack with status flags, error pulses, same-cycle swap and
// a combinational top-of-stack peek.
module param_stack
    import param_stack_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             pop_valid,
    output logic [WIDTH-1:0] top,
    output logic [PTR_W-1:0] count,
    output logic             is_empty,
    output logic             is_full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = clog2(DEPTH);

    logic [PTR_W-1:0] ptr_r;
    logic [WIDTH-1:0] d_out_r;
    logic             pop_valid_r;
    logic             overflow_r;
    logic             underflow_r;

    stack_op_e        op_s;
    logic [AW-1:0]    rd_addr_s;
    logic [WIDTH-1:0] rd_data_s;
    logic             empty_s;
    logic             full_s;
    logic [PTR_W-1:0] ptr_next_s;
    logic             we_s;
    logic [AW-1:0]    waddr_s;
    logic [WIDTH-1:0] wdata_s;
    logic             d_out_load_s;
    logic [WIDTH-1:0] d_out_next_s;
    logic             pop_valid_next_s;
    logic             overflow_next_s;
    logic             underflow_next_s;

    assign op_s      = stack_op_e'({push, pop});
    assign empty_s   = (ptr_r == {PTR_W{1'b0}});
    assign full_s    = (ptr_r == PTR_W'(DEPTH));
    // ptr-1 wraps to all-ones when empty; that address is never consumed then.
    assign rd_addr_s = AW'(ptr_r - PTR_W'(1));

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .raddr (rd_addr_s),
        .rdata (rd_data_s)
    );

    // Operation decode: push/pop against full/empty into next-state controls.
    always_comb begin
        ptr_next_s       = ptr_r;
        we_s             = 1'b0;
        waddr_s          = AW'(ptr_r);
        wdata_s          = d_in;
        d_out_load_s     = 1'b0;
        d_out_next_s     = rd_data_s;
        pop_valid_next_s = 1'b0;
        overflow_next_s  = 1'b0;
        underflow_next_s = 1'b0;
        if (rst) begin
            ptr_next_s = {PTR_W{1'b0}};
        end else begin
            case (op_s)
                OP_PUSH: begin
                    if (!full_s) begin
                        we_s       = 1'b1;
                        ptr_next_s = ptr_r + PTR_W'(1);
                    end else begin
                        overflow_next_s = 1'b1;
                    end
                end
                OP_POP: begin
                    if (!empty_s) begin
                        d_out_load_s     = 1'b1;
                        pop_valid_next_s = 1'b1;
                        ptr_next_s       = ptr_r - PTR_W'(1);
                    end else begin
                        underflow_next_s = 1'b1;
                    end
                end
                OP_SWAP: begin
                    d_out_load_s     = 1'b1;
                    pop_valid_next_s = 1'b1;
                    if (!empty_s) begin
                        we_s    = 1'b1;
                        waddr_s = rd_addr_s;
                    end else begin
                        d_out_next_s = d_in;
                    end
                end
                OP_IDLE: begin
                    ptr_next_s = ptr_r;
                end
                default: begin
                    ptr_next_s = ptr_r;
                end
            endcase
        end
    end

    // State and pulse registers; reset dominates any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r       <= {PTR_W{1'b0}};
            d_out_r     <= {WIDTH{1'b0}};
            pop_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            ptr_r       <= ptr_next_s;
            pop_valid_r <= pop_valid_next_s;
            overflow_r  <= overflow_next_s;
            underflow_r <= underflow_next_s;
            if (d_out_load_s) begin
                d_out_r <= d_out_next_s;
            end
        end
    end

    assign d_out     = d_out_r;
    assign pop_valid = pop_valid_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    assign count     = ptr_r;
    assign is_empty  = empty_s;
    assign is_full   = full_s;
    assign top       = empty_s ? {WIDTH{1'b0}} : rd_data_s;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench: a DEPTH=4 stack for the functional cases and a DEPTH=512
// stack, driven by the same inputs, for the full-depth LIFO smoke test.
module tb_param_stack;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [2:0] d_in = 3'd0;

    logic [2:0] s_d_out, s_top;
    logic [2:0] s_count;
    logic       s_pop_valid, s_is_empty, s_is_full, s_overflow, s_underflow;

    logic [2:0] b_d_out, b_top;
    logic [9:0] b_count;
    logic       b_pop_valid, b_is_empty, b_is_full, b_overflow, b_underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_stack #(.WIDTH(3), .DEPTH(4)) u_small (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .d_in(d_in),
        .d_out(s_d_out), .pop_valid(s_pop_valid), .top(s_top), .count(s_count),
        .is_empty(s_is_empty), .is_full(s_is_full),
        .overflow(s_overflow), .underflow(s_underflow)
    );

    param_stack #(.WIDTH(3), .DEPTH(512)) u_big (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .d_in(d_in),
        .d_out(b_d_out), .pop_valid(b_pop_valid), .top(b_top), .count(b_count),
        .is_empty(b_is_empty), .is_full(b_is_full),
        .overflow(b_overflow), .underflow(b_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic r, input logic p, input logic q, input logic [2:0] d);
        rst  = r;
        push = p;
        pop  = q;
        d_in = d;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 3'd0);
        chk("rst_count", s_count, 0);
        chk("rst_empty", s_is_empty, 1);
        chk("rst_full", s_is_full, 0);
        chk("rst_dout", s_d_out, 0);
        chk("rst_pv", s_pop_valid, 0);
        chk("rst_top", s_top, 0);
        chk("rst_pulses", {s_overflow, s_underflow}, 0);

        // 1. push 5,6,7 then pop three times
        cyc(1'b0, 1'b1, 1'b0, 3'd5);
        chk("t1_top_after_5", s_top, 5);
        cyc(1'b0, 1'b1, 1'b0, 3'd6);
        cyc(1'b0, 1'b1, 1'b0, 3'd7);
        chk("t1_count", s_count, 3);
        chk("t1_top", s_top, 7);
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        chk("t1_pop1_dout", s_d_out, 7);
        chk("t1_pop1_pv", s_pop_valid, 1);
        chk("t1_pop1_count", s_count, 2);
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        chk("t1_pop2_dout", s_d_out, 6);
        chk("t1_pop2_pv", s_pop_valid, 1);
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        chk("t1_pop3_dout", s_d_out, 5);
        chk("t1_pop3_pv", s_pop_valid, 1);
        chk("t1_empty", s_is_empty, 1);
        chk("t1_top_empty", s_top, 0);
        cyc(1'b0, 1'b0, 1'b0, 3'd0);
        chk("t1_idle_pv", s_pop_valid, 0);
        chk("t1_idle_dout", s_d_out, 5);

        // 2. fill and overflow
        cyc(1'b0, 1'b1, 1'b0, 3'd1);
        cyc(1'b0, 1'b1, 1'b0, 3'd2);
        cyc(1'b0, 1'b1, 1'b0, 3'd3);
        chk("t2_not_full", s_is_full, 0);
        cyc(1'b0, 1'b1, 1'b0, 3'd4);
        chk("t2_full", s_is_full, 1);
        chk("t2_count4", s_count, 4);
        cyc(1'b0, 1'b1, 1'b0, 3'd1);
        chk("t2_overflow", s_overflow, 1);
        chk("t2_ovf_count", s_count, 4);
        chk("t2_ovf_top", s_top, 4);
        chk("t2_ovf_pv", {s_pop_valid, s_underflow}, 0);
        cyc(1'b0, 1'b0, 1'b0, 3'd0);
        chk("t2_ovf_pulse_end", s_overflow, 0);

        // 3. drain, then pop on empty
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        chk("t3_drain_dout", s_d_out, 1);
        chk("t3_drain_empty", s_is_empty, 1);
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        chk("t3_underflow", s_underflow, 1);
        chk("t3_unf_pv", s_pop_valid, 0);
        chk("t3_unf_dout", s_d_out, 1);
        chk("t3_unf_count", s_count, 0);
        cyc(1'b0, 1'b0, 1'b0, 3'd0);
        chk("t3_unf_pulse_end", s_underflow, 0);

        // 4. swap on [1,2], then swap when full
        cyc(1'b0, 1'b1, 1'b0, 3'd1);
        cyc(1'b0, 1'b1, 1'b0, 3'd2);
        cyc(1'b0, 1'b1, 1'b1, 3'd6);
        chk("t4_swap_dout", s_d_out, 2);
        chk("t4_swap_pv", s_pop_valid, 1);
        chk("t4_swap_count", s_count, 2);
        chk("t4_swap_top", s_top, 6);
        cyc(1'b0, 1'b1, 1'b0, 3'd3);
        cyc(1'b0, 1'b1, 1'b0, 3'd4);
        cyc(1'b0, 1'b1, 1'b1, 3'd7);
        chk("t4_full_swap_dout", s_d_out, 4);
        chk("t4_full_swap_ovf", s_overflow, 0);
        chk("t4_full_swap_count", s_count, 4);
        chk("t4_full_swap_top", s_top, 7);
        chk("t4_full_swap_pv", s_pop_valid, 1);
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        chk("t4_below_swap", s_d_out, 6);

        // 5. pass-through on empty stack
        cyc(1'b1, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, 1'b1, 3'd3);
        chk("t5_pass_dout", s_d_out, 3);
        chk("t5_pass_pv", s_pop_valid, 1);
        chk("t5_pass_count", s_count, 0);
        chk("t5_pass_pulses", {s_overflow, s_underflow}, 0);
        chk("t5_pass_top", s_top, 0);

        // 6. reset together with push mid-sequence
        cyc(1'b0, 1'b1, 1'b0, 3'd1);
        cyc(1'b0, 1'b1, 1'b0, 3'd2);
        cyc(1'b0, 1'b1, 1'b0, 3'd3);
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        chk("t6_pre_dout", s_d_out, 3);
        cyc(1'b1, 1'b1, 1'b0, 3'd5);
        chk("t6_count", s_count, 0);
        chk("t6_empty", s_is_empty, 1);
        chk("t6_dout", s_d_out, 0);
        chk("t6_pulses", {s_pop_valid, s_overflow, s_underflow}, 0);
        chk("t6_top", s_top, 0);

        // DEPTH=512 smoke test
        chk("big_empty", b_is_empty, 1);
        for (int i = 0; i < 512; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 3'(i % 8));
        end
        chk("big_full", b_is_full, 1);
        chk("big_count", b_count, 512);
        chk("big_top", b_top, 7);
        cyc(1'b0, 1'b1, 1'b0, 3'd2);
        chk("big_overflow", b_overflow, 1);
        for (int k = 0; k < 512; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 3'd0);
            chk("big_pop_dout", b_d_out, (511 - k) % 8);
            chk("big_pop_pv", b_pop_valid, 1);
        end
        chk("big_end_empty", b_is_empty, 1);
        chk("big_end_count", b_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
